// File: rtl/seq_pkg.sv
// Shared step-sequencer geometry: grid dimensions and the step/instrument
// to square index rule used by both the sequencer and the VGA renderer.
package seq_pkg;

  localparam int unsigned NUM_STEPS   = 8;
  localparam int unsigned NUM_INST    = 4;
  localparam int unsigned NUM_SQUARES = NUM_STEPS * NUM_INST;

  typedef logic [$clog2(NUM_STEPS)-1:0]   step_t;
  typedef logic [$clog2(NUM_INST)-1:0]    inst_t;
  typedef logic [$clog2(NUM_SQUARES)-1:0] square_t;

  // Square index = step*4 + inst (column = step, row = instrument).
  function automatic square_t square_index(input step_t step, input inst_t inst);
    return {step, inst};
  endfunction

endpackage

// File: rtl/tempo_divider.sv
// Step-period divider: counts clk cycles while enabled and flags the cycle in
// which the current step period expires (period = TICK_DIV >> tempo_sel).
module tempo_divider #(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] tempo_sel,
  output logic       tick
);

  localparam int unsigned   CW  = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

  logic [CW-1:0] count;
  logic [CW-1:0] limit;

  always_comb limit = (DIV >> tempo_sel) - CW'(1);

  // tick is combinational so the parent can advance timing and raise its
  // registered step_tick on the same edge; >= handles a tempo change that
  // leaves the count already past the new limit.
  assign tick = en && (count >= limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (!en || tick)
      count <= '0;
    else
      count <= count + CW'(1);
  end

endmodule

// File: rtl/step_sequencer.sv
// 8-step x 4-instrument drum pattern sequencer: pattern storage with
// edge-detected cell toggles and clear, step timing, and instrument enables.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [1:0] tempo_sel,
  input  logic [1:0] edit_inst,
  input  logic [2:0] edit_step,
  input  logic       edit_toggle,
  input  logic       clear,
  input  logic [4:0] rd_square,
  output logic       rd_on,
  output logic       ins1,
  output logic       ins2,
  output logic       ins3,
  output logic       ins4,
  output logic [2:0] timing,
  output logic       step_tick
);

  logic [NUM_SQUARES-1:0] pattern;
  logic [NUM_INST-1:0]    ins_q;
  logic                   toggle_q;
  logic                   toggle_rise;
  logic                   advance;

  tempo_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tempo_divider (
    .clk       (clk),
    .reset     (reset),
    .en        (play),
    .tempo_sel (tempo_sel),
    .tick      (advance)
  );

  assign toggle_rise = edit_toggle & ~toggle_q;

  // Pattern edits are independent of play; clear wins over a toggle edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern  <= '0;
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= edit_toggle;
      if (clear)
        pattern <= '0;
      else if (toggle_rise)
        pattern[square_index(edit_step, edit_inst)] <= ~pattern[square_index(edit_step, edit_inst)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timing    <= '0;
      step_tick <= 1'b0;
      ins_q     <= '0;
    end else begin
      step_tick <= advance;
      if (advance)
        timing <= timing + 3'd1;
      ins_q <= play ? pattern[square_index(timing, '0) +: NUM_INST] : '0;
    end
  end

  assign rd_on = pattern[rd_square];
  assign {ins4, ins3, ins2, ins1} = ins_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer with TICK_DIV=8.
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic [1:0] tempo_sel = '0;
  logic [1:0] edit_inst = '0;
  logic [2:0] edit_step = '0;
  logic       edit_toggle = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] rd_square = '0;
  logic       rd_on;
  logic       ins1, ins2, ins3, ins4;
  logic [2:0] timing;
  logic       step_tick;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pat = '0;

  always #5 clk = ~clk;

  step_sequencer #(
    .TICK_DIV (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .tempo_sel   (tempo_sel),
    .edit_inst   (edit_inst),
    .edit_step   (edit_step),
    .edit_toggle (edit_toggle),
    .clear       (clear),
    .rd_square   (rd_square),
    .rd_on       (rd_on),
    .ins1        (ins1),
    .ins2        (ins2),
    .ins3        (ins3),
    .ins4        (ins4),
    .timing      (timing),
    .step_tick   (step_tick)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; play = 1'b0; tempo_sel = '0; edit_toggle = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_pat = '0;
  endtask

  task automatic toggle_cell(input int s, input int i);
    @(negedge clk);
    edit_step = 3'(s); edit_inst = 2'(i); edit_toggle = 1'b1;
    @(negedge clk);
    edit_toggle = 1'b0;
    exp_pat[s*4+i] = ~exp_pat[s*4+i];
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({timing, step_tick, ins4, ins3, ins2, ins1, rd_on} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got t=%0d tick=%0b ins=%b rd_on=%0b want all 0",
               timing, step_tick, {ins4, ins3, ins2, ins1}, rd_on);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_play();
    int exp_t;
    logic exp_tick;
    @(negedge clk);
    play = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        exp_tick = (c == 8);
        exp_t = (c == 8) ? (s % 8) : ((s - 1) % 8);
        checks++;
        if (step_tick !== exp_tick || timing !== 3'(exp_t)) begin
          errors++;
          $display("FAIL play_step s%0d c%0d: got tick=%0b t=%0d want tick=%0b t=%0d",
                   s, c, step_tick, timing, exp_tick, exp_t);
        end
      end
    end
    play = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (step_tick !== 1'b0 || timing !== 3'd1) begin
        errors++;
        $display("FAIL play_hold c%0d: got tick=%0b t=%0d want tick=0 t=1", c, step_tick, timing);
      end
    end
  endtask

  task automatic test_toggle();
    @(negedge clk);
    edit_step = 3'd2; edit_inst = 2'd1; edit_toggle = 1'b1;
    repeat (5) @(negedge clk);
    edit_toggle = 1'b0;
    exp_pat[9] = 1'b1;
    for (int sq = 0; sq < 32; sq++) begin
      rd_square = 5'(sq);
      #1;
      checks++;
      if (rd_on !== exp_pat[sq]) begin
        errors++;
        $display("FAIL toggle_hold sq%0d: got %0b want %0b", sq, rd_on, exp_pat[sq]);
      end
    end
    toggle_cell(2, 1);
    rd_square = 5'd9;
    #1;
    checks++;
    if (rd_on !== 1'b0 || exp_pat[9] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_second: got %0b want 0", rd_on);
    end
  endtask

  task automatic test_ins();
    logic [3:0] exp_ins;
    int s;
    do_reset();
    toggle_cell(0, 0);
    toggle_cell(1, 3);
    @(negedge clk);
    checks++;
    if ({ins4, ins3, ins2, ins1} !== 4'b0) begin
      errors++;
      $display("FAIL ins_idle: got %b want 0000", {ins4, ins3, ins2, ins1});
    end
    play = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      s = (k - 1) / 8;
      exp_ins = exp_pat[s*4 +: 4];
      checks++;
      if ({ins4, ins3, ins2, ins1} !== exp_ins) begin
        errors++;
        $display("FAIL ins_play k%0d: got %b want %b", k, {ins4, ins3, ins2, ins1}, exp_ins);
      end
    end
    play = 1'b0;
    @(negedge clk);
    checks++;
    if ({ins4, ins3, ins2, ins1, step_tick} !== 5'b0) begin
      errors++;
      $display("FAIL ins_stop: got ins=%b tick=%0b want 0", {ins4, ins3, ins2, ins1}, step_tick);
    end
  endtask

  task automatic test_clear_priority();
    toggle_cell(4, 2);
    toggle_cell(7, 3);
    rd_square = 5'd18;
    #1;
    checks++;
    if (rd_on !== exp_pat[18]) begin
      errors++;
      $display("FAIL clear_setup: got %0b want %0b", rd_on, exp_pat[18]);
    end
    @(negedge clk);
    edit_step = 3'd5; edit_inst = 2'd0; edit_toggle = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_pat = '0;
    for (int sq = 0; sq < 32; sq++) begin
      rd_square = 5'(sq);
      #1;
      checks++;
      if (rd_on !== exp_pat[sq]) begin
        errors++;
        $display("FAIL clear_prio sq%0d: got %0b want 0", sq, rd_on);
      end
    end
    @(negedge clk);
    rd_square = 5'd20;
    #1;
    checks++;
    if (rd_on !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold_toggle: got %0b want 0", rd_on);
    end
    edit_toggle = 1'b0;
  endtask

  task automatic test_tempo();
    do_reset();
    @(negedge clk);
    play = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (timing !== 3'd0 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL tempo_pre: got t=%0d tick=%0b want t=0 tick=0", timing, step_tick);
    end
    tempo_sel = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (timing !== 3'(k) || step_tick !== 1'b1) begin
        errors++;
        $display("FAIL tempo_fast k%0d: got t=%0d tick=%0b want t=%0d tick=1", k, timing, step_tick, k);
      end
    end
    play = 1'b0;
    tempo_sel = 2'd0;
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    do_reset();
    toggle_cell(5, 0);
    rd_square = 5'd20;
    @(negedge clk);
    play = 1'b1;
    repeat (43) @(negedge clk);
    checks++;
    if (timing !== 3'd5 || ins1 !== 1'b1 || rd_on !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got t=%0d ins1=%0b rd_on=%0b want t=5 ins1=1 rd_on=1", timing, ins1, rd_on);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({timing, step_tick, ins4, ins3, ins2, ins1, rd_on} !== 9'b0) begin
      errors++;
      $display("FAIL rstmid_async: got t=%0d tick=%0b ins=%b rd_on=%0b want all 0",
               timing, step_tick, {ins4, ins3, ins2, ins1}, rd_on);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_pat = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_tick = (c == 8);
      checks++;
      if (step_tick !== exp_tick || timing !== (exp_tick ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL rstmid_resume c%0d: got tick=%0b t=%0d want tick=%0b t=%0d",
                 c, step_tick, timing, exp_tick, exp_tick ? 1 : 0);
      end
    end
    play = 1'b0;
  endtask

  initial begin
    test_reset();
    test_play();
    test_toggle();
    test_ins();
    test_clear_priority();
    test_tempo();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 6250000, base clock cycles per step at tempo_sel=0 (8 steps/s at 50 MHz).
REQ-002 Port clk  input  1  system clock (50 MHz).
REQ-003 Port reset  input  1  asynchronous, active-low reset; one clock domain (clk) only.
REQ-004 Port play  input  1  high = sequencer running.
REQ-005 Port tempo_sel  input  2  step period = TICK_DIV >> tempo_sel cycles.
REQ-006 Port edit_inst  input  2  instrument row of cell to toggle (0..3 = ins1..ins4).
REQ-007 Port edit_step  input  3  step column of cell to toggle.
REQ-008 Port edit_toggle  input  1  toggle request, level from debounced key.
REQ-009 Port clear  input  1  synchronous clear of entire pattern.
REQ-010 Port rd_square  input  5  renderer read address, index = step*4 + inst.
REQ-011 Port rd_on  output  1  pattern bit at rd_square, combinational.
REQ-012 Ports ins1, ins2, ins3, ins4  output  1 each  current-step instrument enables, registered.
REQ-013 Port timing  output  3  current step 0..7, registered.
REQ-014 Port step_tick  output  1  one-cycle pulse in the cycle timing changes.

Function
REQ-015 Pattern SHALL be 32 bits, bit index step*4 + inst, matching the renderer square numbering (column = step, row = instrument).
REQ-016 Divider counter SHALL increment each cycle while play=1; when count >= (TICK_DIV >> tempo_sel) - 1, it SHALL clear to 0, timing SHALL advance by 1, and step_tick SHALL pulse.
REQ-017 timing SHALL wrap 7 -> 0 with no gap cycle.
REQ-018 A tempo_sel change that leaves count >= new limit - 1 SHALL cause an advance on the next clock edge, not a counter wrap.
REQ-019 While play=0, the divider SHALL hold at 0, timing SHALL hold, step_tick SHALL be 0, and ins1..ins4 SHALL be 0.
REQ-020 On play 0->1, the first advance SHALL occur after one full step period; timing SHALL resume from its held value.
REQ-021 ins(k+1) SHALL be registered from pattern[timing*4+k] & play each cycle; latency is 1 cycle from a timing or pattern change.
REQ-022 edit_toggle SHALL be rising-edge detected against a registered copy; each rising edge SHALL invert exactly one cell, [edit_step*4+edit_inst], at that clock edge. Holding the input high SHALL NOT cause repeated toggles.
REQ-023 clear=1 SHALL zero all 32 bits at the next edge; clear SHALL take priority over a simultaneous toggle.
REQ-024 Editing the currently playing cell SHALL be reflected on the ins output one edge after the pattern update.
REQ-025 Edits and clear SHALL work regardless of play.

Reset
REQ-026 reset=0 SHALL asynchronously force pattern=0, timing=0, divider=0, ins1..ins4=0, step_tick=0, and the toggle-edge register=0.
REQ-027 Reset asserted mid-step SHALL discard partial divider progress; after release, the first advance SHALL occur a full period later.

Structure
REQ-028 Shared package seq_pkg SHALL hold NUM_STEPS=8, NUM_INST=4, NUM_SQUARES=32, and the step/instrument-to-square index rule, for reuse by the VGA renderer.
REQ-029 The divider SHALL be a sub-module tempo_divider (inputs clk, reset, en, tempo_sel; output tick); pattern storage and edit logic SHALL reside in step_sequencer.

Verification (TICK_DIV=8)
REQ-030 Reset, then play=1 with tempo_sel=0 -> step_tick every 8 cycles; timing 0,1,..,7,0; first tick 8 cycles after play rises.
REQ-031 edit_step=2, edit_inst=1, edit_toggle held high for 5 cycles -> only bit 9 set; rd_square=9 gives rd_on=1; a second rising edge clears it.
REQ-032 Pattern bits 0 and 7 set, play running -> ins1=1 while timing=0, ins4=1 while timing=1, 1-cycle lag; all ins=0 while play=0.
REQ-033 clear and a toggle rising edge in the same cycle -> pattern all 0.
REQ-034 tempo_sel 0->3 when count=5 -> advance at next edge, then period of 1 cycle.
REQ-035 reset asserted at timing=5, mid-period -> all outputs 0 immediately (asynchronous); after release, first tick 8 cycles later.
